// File: rtl/seq_pattern_detector_if.sv
// Bus bundle for seq_pattern_detector: serial stream, pattern/config load and match status.
interface seq_pattern_detector_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             in;
   logic             in_valid;
   logic [PAT_W-1:0] pattern;
   logic             pat_load;
   logic             overlap;
   logic             cnt_clr;
   logic             detect;
   logic [CNT_W-1:0] match_count;
   logic             count_sat;

   modport master (
      output in, in_valid, pattern, pat_load, overlap, cnt_clr,
      input  detect, match_count, count_sat
   );

   modport slave (
      input  in, in_valid, pattern, pat_load, overlap, cnt_clr,
      output detect, match_count, count_sat
   );
endinterface

// File: rtl/seq_pattern_detector.sv
// Moore serial pattern detector with runtime-loadable pattern and overlap mode.
// Optional saturating match counter enabled by defining SEQDET_COUNT_EN.
//
// state   | meaning
// UNARMED | no pattern loaded since reset, stream ignored
// FILL    | collecting the first PAT_W bits after load or non-overlap hit
// SEARCH  | history full, sliding compare on each valid bit
// HIT     | history equals pattern, detect asserted
module seq_pattern_detector #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seq_pattern_detector_if.slave  bus
);
   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
   localparam logic [FW-1:0] FILL_ONE  = FW'(1);

   typedef enum logic [1:0] {UNARMED, FILL, SEARCH, HIT} state_t;

   state_t           r_state, w_state_nxt;
   logic [PAT_W-1:0] r_hist, w_hist_nxt;
   logic [PAT_W-1:0] r_pat, w_pat_nxt;
   logic             r_ovl, w_ovl_nxt;
   logic [FW-1:0]    r_fill, w_fill_nxt;
   logic [PAT_W-1:0] w_hist_shift;
   logic [PAT_W-1:0] w_hist_one;
   logic [FW-1:0]    w_fill_inc;
   logic             w_shift_match;
   logic             w_one_match;
   logic             w_hit_enter;

   assign w_hist_shift  = (r_hist << 1) | PAT_W'(bus.in);
   assign w_hist_one    = PAT_W'(bus.in);
   assign w_fill_inc    = r_fill + FILL_ONE;
   assign w_shift_match = (w_hist_shift == r_pat);
   assign w_one_match   = (w_hist_one == r_pat);

   always_comb begin
      w_state_nxt = r_state;
      w_hist_nxt  = r_hist;
      w_fill_nxt  = r_fill;
      w_pat_nxt   = r_pat;
      w_ovl_nxt   = r_ovl;
      w_hit_enter = 1'b0;
      if (bus.pat_load) begin
         w_pat_nxt   = bus.pattern;
         w_ovl_nxt   = bus.overlap;
         w_hist_nxt  = '0;
         w_fill_nxt  = '0;
         w_state_nxt = FILL;
      end else if (bus.in_valid) begin
         unique case (r_state)
            FILL: begin
               w_hist_nxt = w_hist_shift;
               w_fill_nxt = w_fill_inc;
               if (w_fill_inc == FILL_FULL)
                  w_state_nxt = w_shift_match ? HIT : SEARCH;
            end
            SEARCH: begin
               w_hist_nxt = w_hist_shift;
               if (w_shift_match)
                  w_state_nxt = HIT;
            end
            HIT: begin
               if (r_ovl) begin
                  w_hist_nxt  = w_hist_shift;
                  w_state_nxt = w_shift_match ? HIT : SEARCH;
               end else begin
                  // Non-overlap restarts from this bit; a 1-bit history is already full.
                  w_hist_nxt = w_hist_one;
                  w_fill_nxt = FILL_ONE;
                  if (PAT_W == 1)
                     w_state_nxt = w_one_match ? HIT : SEARCH;
                  else
                     w_state_nxt = FILL;
               end
            end
            default: ;
         endcase
         w_hit_enter = (w_state_nxt == HIT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= UNARMED;
         r_hist  <= '0;
         r_fill  <= '0;
         r_pat   <= '0;
         r_ovl   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hist  <= w_hist_nxt;
         r_fill  <= w_fill_nxt;
         r_pat   <= w_pat_nxt;
         r_ovl   <= w_ovl_nxt;
      end
   end

   assign bus.detect = (r_state == HIT);

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (bus.cnt_clr)
         r_count <= '0;
      else if (w_hit_enter && !(&r_count))
         r_count <= r_count + CNT_W'(1);
   end

   assign bus.match_count = r_count;
   assign bus.count_sat   = &r_count;
`else
   wire w_unused_cnt = &{1'b0, bus.cnt_clr, w_hit_enter};

   assign bus.match_count = '0;
   assign bus.count_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: PAT_W=4/CNT_W=2 main instance plus a PAT_W=1 instance.
module tb_seq_pattern_detector;
`ifdef SEQDET_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   seq_pattern_detector_if #(.PAT_W(4), .CNT_W(2)) u_if ();
   seq_pattern_detector_if #(.PAT_W(1), .CNT_W(2)) u_if1 ();

   seq_pattern_detector #(.PAT_W(4), .CNT_W(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(u_if)
   );
   seq_pattern_detector #(.PAT_W(1), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(u_if1)
   );

   function automatic logic [31:0] ec(input int n);
      return CNT_EN ? 32'(n) : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] pat, input logic ovl, input logic clr);
      u_if.pattern  = pat;
      u_if.overlap  = ovl;
      u_if.pat_load = 1'b1;
      u_if.cnt_clr  = clr;
      u_if.in_valid = 1'b0;
      cyc();
      u_if.pat_load = 1'b0;
      u_if.cnt_clr  = 1'b0;
   endtask

   task automatic send(input logic b);
      u_if.in       = b;
      u_if.in_valid = 1'b1;
      cyc();
      u_if.in_valid = 1'b0;
   endtask

   task automatic run(input string tag, input logic [6:0] bits, input logic [6:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         send(bits[n-1-i]);
         chk($sformatf("%s_det%0d", tag, i + 1), 32'(u_if.detect), 32'(exp[n-1-i]));
      end
   endtask

   initial begin
      u_if.in = 1'b0;  u_if.in_valid = 1'b0; u_if.pattern = '0;
      u_if.pat_load = 1'b0; u_if.overlap = 1'b0; u_if.cnt_clr = 1'b0;
      u_if1.in = 1'b0; u_if1.in_valid = 1'b0; u_if1.pattern = '0;
      u_if1.pat_load = 1'b0; u_if1.overlap = 1'b0; u_if1.cnt_clr = 1'b0;

      #12;
      chk("rst_det", 32'(u_if.detect), 32'd0);
      chk("rst_cnt", 32'(u_if.match_count), 32'd0);
      chk("rst_sat", 32'(u_if.count_sat), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // overlapping: 1,0,1,1,0,1,1 -> hits at bits 4 and 7
      load(4'b1011, 1'b1, 1'b0);
      run("ovl", 7'b1011011, 7'b0001001, 7);
      chk("ovl_cnt", 32'(u_if.match_count), ec(2));

      // non-overlapping: same stream, only bit 4 hits
      load(4'b1011, 1'b0, 1'b1);
      run("novl", 7'b1011011, 7'b0001000, 7);
      chk("novl_cnt", 32'(u_if.match_count), ec(1));

      // detect holds through idle cycles, drops on next valid 0
      load(4'b1011, 1'b1, 1'b1);
      run("idle", 7'b0001011, 7'b0000001, 4);
      cyc();
      chk("idle_hold1", 32'(u_if.detect), 32'd1);
      cyc();
      chk("idle_hold2", 32'(u_if.detect), 32'd1);
      send(1'b0);
      chk("idle_fall", 32'(u_if.detect), 32'd0);
      chk("idle_cnt", 32'(u_if.match_count), ec(1));

      // pat_load coincident with a valid bit: the bit and earlier history are discarded
      load(4'b1011, 1'b1, 1'b1);
      send(1'b1);
      send(1'b0);
      u_if.pattern  = 4'b1011;
      u_if.overlap  = 1'b1;
      u_if.pat_load = 1'b1;
      u_if.in       = 1'b1;
      u_if.in_valid = 1'b1;
      cyc();
      u_if.pat_load = 1'b0;
      u_if.in_valid = 1'b0;
      chk("drop_det0", 32'(u_if.detect), 32'd0);
      run("drop", 7'b0001011, 7'b0000001, 4);
      chk("drop_cnt", 32'(u_if.match_count), ec(1));

      // saturation with CNT_W=2: matches 2..5 give 2,3,3,3
      run("sat2", 7'b0000011, 7'b0000001, 3);
      chk("sat_cnt2", 32'(u_if.match_count), ec(2));
      chk("sat_flag2", 32'(u_if.count_sat), 32'd0);
      run("sat3", 7'b0000011, 7'b0000001, 3);
      chk("sat_cnt3", 32'(u_if.match_count), ec(3));
      chk("sat_flag3", 32'(u_if.count_sat), ec(1));
      run("sat4", 7'b0000011, 7'b0000001, 3);
      chk("sat_cnt4", 32'(u_if.match_count), ec(3));
      run("sat5", 7'b0000011, 7'b0000001, 3);
      chk("sat_cnt5", 32'(u_if.match_count), ec(3));
      chk("sat_flag5", 32'(u_if.count_sat), ec(1));

      // cnt_clr coincident with a match wins
      send(1'b0);
      send(1'b1);
      u_if.cnt_clr = 1'b1;
      send(1'b1);
      u_if.cnt_clr = 1'b0;
      chk("clr_det", 32'(u_if.detect), 32'd1);
      chk("clr_cnt", 32'(u_if.match_count), 32'd0);
      chk("clr_sat", 32'(u_if.count_sat), 32'd0);

      // async reset mid-stream
      load(4'b1011, 1'b1, 1'b0);
      run("pre", 7'b1011011, 7'b0001001, 7);
      chk("pre_cnt", 32'(u_if.match_count), ec(2));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_det", 32'(u_if.detect), 32'd0);
      chk("arst_cnt", 32'(u_if.match_count), 32'd0);
      cyc();
      rst_n = 1'b1;
      run("unarmed", 7'b0001011, 7'b0000000, 4);
      chk("unarmed_cnt", 32'(u_if.match_count), 32'd0);
      load(4'b1011, 1'b1, 1'b0);
      run("rearm", 7'b0001011, 7'b0000001, 4);

      // PAT_W=1, non-overlapping: 1,1,0,1 -> 1,1,0,1
      u_if1.pattern  = 1'b1;
      u_if1.overlap  = 1'b0;
      u_if1.pat_load = 1'b1;
      cyc();
      u_if1.pat_load = 1'b0;
      begin
         logic [3:0] bits1;
         bits1 = 4'b1101;
         for (int i = 0; i < 4; i++) begin
            u_if1.in       = bits1[3-i];
            u_if1.in_valid = 1'b1;
            cyc();
            u_if1.in_valid = 1'b0;
            chk($sformatf("w1_det%0d", i + 1), 32'(u_if1.detect), 32'(bits1[3-i]));
         end
      end
      chk("w1_cnt", 32'(u_if1.match_count), ec(3));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
